// File: rtl/timer_pkg.sv
// timer_pkg -- shared types and constants for the 16-bit timer/counter.
//   state_e     : waveform controller FSM states
//   mode_t      : waveform/sequencing mode bits taken from TCCR
//   TCCR_*      : bit positions inside the TCCR control register
//   TOP_*       : TOP value encodings from TCCR2[11:8] and their decode
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Mode bits as seen by the waveform controller in a given cycle.
  typedef struct packed {
    logic fpwm;
    logic cc;
    logic per;
    logic pol;
  } mode_t;

  // TCCR bit indices.
  localparam int TCCR_EN        = 0;
  localparam int TCCR_MODE_CC   = 8;
  localparam int TCCR_MODE_PER  = 9;
  localparam int TCCR_MODE_FPWM = 10;
  localparam int TCCR_POL       = 11;

  // TCCR2[11:8] TOP encodings; any other code selects the full 16-bit range.
  localparam logic [3:0] TOP_BIT08 = 4'd0;
  localparam logic [3:0] TOP_BIT09 = 4'd1;
  localparam logic [3:0] TOP_BIT10 = 4'd2;
  localparam logic [3:0] TOP_BIT11 = 4'd3;
  localparam logic [3:0] TOP_BIT12 = 4'd4;
  localparam logic [3:0] TOP_BIT13 = 4'd5;
  localparam logic [3:0] TOP_BIT14 = 4'd6;
  localparam logic [3:0] TOP_BIT15 = 4'd7;

  localparam logic [15:0] TOP_VAL_BIT08   = 16'h00FF;
  localparam logic [15:0] TOP_VAL_BIT09   = 16'h01FF;
  localparam logic [15:0] TOP_VAL_BIT10   = 16'h03FF;
  localparam logic [15:0] TOP_VAL_BIT11   = 16'h07FF;
  localparam logic [15:0] TOP_VAL_BIT12   = 16'h0FFF;
  localparam logic [15:0] TOP_VAL_BIT13   = 16'h1FFF;
  localparam logic [15:0] TOP_VAL_BIT14   = 16'h3FFF;
  localparam logic [15:0] TOP_VAL_BIT15   = 16'h7FFF;
  localparam logic [15:0] TOP_VAL_DEFAULT = 16'hFFFF;

  // Decode a TCCR2[11:8] TOP code into the counter TOP value.
  function automatic logic [15:0] decode_top(input logic [3:0] code);
    logic [15:0] val;
    case (code)
      TOP_BIT08: val = TOP_VAL_BIT08;
      TOP_BIT09: val = TOP_VAL_BIT09;
      TOP_BIT10: val = TOP_VAL_BIT10;
      TOP_BIT11: val = TOP_VAL_BIT11;
      TOP_BIT12: val = TOP_VAL_BIT12;
      TOP_BIT13: val = TOP_VAL_BIT13;
      TOP_BIT14: val = TOP_VAL_BIT14;
      TOP_BIT15: val = TOP_VAL_BIT15;
      default:   val = TOP_VAL_DEFAULT;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/tc_event_detect.sv
// tc_event_detect -- combinational wrap / compare-match detection.
//   cnt_i   : current counter value
//   top_i   : TOP value
//   ocr_i   : output compare value
//   dir_i   : 1 = counting up, 0 = counting down
//   tick_i  : counter changed this cycle; events only qualify on a tick
//   wrap_o  : counter sits at its wrap point (TOP when up, 0 when down)
//   match_o : counter equals the compare value
module tc_event_detect #(
  parameter int W = 16
) (
  input  logic [W-1:0] cnt_i,
  input  logic [W-1:0] top_i,
  input  logic [W-1:0] ocr_i,
  input  logic         dir_i,
  input  logic         tick_i,
  output logic         wrap_o,
  output logic         match_o
);

  logic at_top;
  logic at_zero;
  logic ocr_reach;

  assign at_top  = (cnt_i == top_i);
  assign at_zero = (cnt_i == '0);

  // The counter only ever spans 0..TOP, so a compare value above TOP can
  // never be reached; gate it explicitly so a stray counter value (e.g.
  // just after TOP is lowered) cannot produce a spurious match.
  assign ocr_reach = (ocr_i <= top_i);

  assign wrap_o  = tick_i & (dir_i ? at_top : at_zero);
  assign match_o = tick_i & ocr_reach & (cnt_i == ocr_i);

endmodule

// File: rtl/waveform_ctrl.sv
// waveform_ctrl -- waveform and event controller for the timer/counter.
// Watches the counter on each prescaler tick, raises wrap / compare-match
// pulses, drives the output pin (normal, compare-toggle, fast PWM) and
// sequences single-shot vs periodic operation.
//   i_sysclk, i_sysrst : clock, synchronous active-high reset
//   i_en               : global enable
//   i_cnt_tick         : counter changed this cycle
//   i_cnt_data/dir     : counter value and direction (1 = up)
//   i_top, i_ocr       : TOP and output-compare values
//   i_mode_*, i_pol    : mode selects and output polarity (1 = inverted)
//   o_out_pin          : registered waveform ^ polarity
//   o_ovf_flg/ocm_flg  : one-cycle wrap / match pulses
//   o_cnt_wrap(_val)   : one-cycle reload request and reload value
//   o_cnt_stop         : freeze the counter (single-shot finished)
//   o_busy             : controller is in RUN
module waveform_ctrl
  import timer_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         i_sysclk,
  input  logic         i_sysrst,
  input  logic         i_en,
  input  logic         i_cnt_tick,
  input  logic [W-1:0] i_cnt_data,
  input  logic         i_cnt_dir,
  input  logic [W-1:0] i_top,
  input  logic [W-1:0] i_ocr,
  input  logic         i_mode_cc,
  input  logic         i_mode_per,
  input  logic         i_mode_fpwm,
  input  logic         i_pol,
  output logic         o_out_pin,
  output logic         o_ovf_flg,
  output logic         o_ocm_flg,
  output logic         o_cnt_wrap,
  output logic [W-1:0] o_cnt_wrap_val,
  output logic         o_cnt_stop,
  output logic         o_busy
);

  mode_t mode;
  assign mode = '{fpwm: i_mode_fpwm, cc: i_mode_cc, per: i_mode_per, pol: i_pol};

  logic wrap_evt;
  logic match_evt;

  tc_event_detect #(.W(W)) u_detect (
    .cnt_i   (i_cnt_data),
    .top_i   (i_top),
    .ocr_i   (i_ocr),
    .dir_i   (i_cnt_dir),
    .tick_i  (i_cnt_tick),
    .wrap_o  (wrap_evt),
    .match_o (match_evt)
  );

  state_e         state_q, state_d;
  logic           wave_q, wave_d;
  logic           pin_q;
  logic           ovf_q, ovf_d;
  logic           ocm_q, ocm_d;
  logic           wrap_q, wrap_d;
  logic [W-1:0]   wrap_val_q, wrap_val_d;
  logic           stop_q;
  logic           busy_q;

  always_comb begin
    state_d    = state_q;
    wave_d     = wave_q;
    ovf_d      = 1'b0;
    ocm_d      = 1'b0;
    wrap_d     = 1'b0;
    wrap_val_d = wrap_val_q;
    case (state_q)
      IDLE: begin
        wave_d = 1'b0;
        if (i_en) begin
          state_d = RUN;
          // Fast PWM starts in its "high" phase as if a wrap just happened.
          wave_d  = mode.fpwm;
        end
      end
      RUN: begin
        if (!i_en) begin
          // Disable wins over any event in the same cycle.
          state_d = IDLE;
          wave_d  = 1'b0;
        end else begin
          ovf_d  = wrap_evt;
          ocm_d  = match_evt;
          wrap_d = wrap_evt;
          if (wrap_evt) wrap_val_d = i_cnt_dir ? '0 : i_top;
          // Mode is sampled live; a change only shows at the next event.
          if (mode.fpwm) begin
            if (wrap_evt)       wave_d = 1'b1;
            else if (match_evt) wave_d = 1'b0;
          end else if (mode.cc) begin
            if (match_evt) wave_d = ~wave_q;
          end else begin
            if (wrap_evt || match_evt) wave_d = 1'b0;
          end
          if (wrap_evt && !mode.per) state_d = DONE;
        end
      end
      DONE: begin
        // Waveform holds its last level until disabled.
        if (!i_en) begin
          state_d = IDLE;
          wave_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        wave_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_sysclk) begin
    if (i_sysrst) begin
      state_q    <= IDLE;
      wave_q     <= 1'b0;
      pin_q      <= 1'b0;
      ovf_q      <= 1'b0;
      ocm_q      <= 1'b0;
      wrap_q     <= 1'b0;
      wrap_val_q <= '0;
      stop_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wave_q     <= wave_d;
      pin_q      <= wave_d ^ mode.pol;
      ovf_q      <= ovf_d;
      ocm_q      <= ocm_d;
      wrap_q     <= wrap_d;
      wrap_val_q <= wrap_val_d;
      stop_q     <= (state_d == DONE);
      busy_q     <= (state_d == RUN);
    end
  end

  assign o_out_pin      = pin_q;
  assign o_ovf_flg      = ovf_q;
  assign o_ocm_flg      = ocm_q;
  assign o_cnt_wrap     = wrap_q;
  assign o_cnt_wrap_val = wrap_val_q;
  assign o_cnt_stop     = stop_q;
  assign o_busy         = busy_q;

endmodule

// File: tb/tb_waveform_ctrl.sv
module tb_waveform_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, tick, dir, cc, per, fpwm, pol;
  logic [15:0] cnt, top, ocr;
  logic        pin, ovf, ocm, wrap, stop, busy;
  logic [15:0] wval;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  waveform_ctrl #(.W(16)) dut (
    .i_sysclk       (clk),
    .i_sysrst       (rst),
    .i_en           (en),
    .i_cnt_tick     (tick),
    .i_cnt_data     (cnt),
    .i_cnt_dir      (dir),
    .i_top          (top),
    .i_ocr          (ocr),
    .i_mode_cc      (cc),
    .i_mode_per     (per),
    .i_mode_fpwm    (fpwm),
    .i_pol          (pol),
    .o_out_pin      (pin),
    .o_ovf_flg      (ovf),
    .o_ocm_flg      (ocm),
    .o_cnt_wrap     (wrap),
    .o_cnt_wrap_val (wval),
    .o_cnt_stop     (stop),
    .o_busy         (busy)
  );

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic disable_idle();
    en = 0; tick = 0;
    step();
  endtask

  task automatic test_reset();
    rst = 1; en = 0; tick = 0; dir = 1; cc = 0; per = 0; fpwm = 0; pol = 1;
    cnt = 0; top = 0; ocr = 0;
    step(); step();
    checks++;
    if ({pin, ovf, ocm, wrap, wval, stop, busy} !== 22'd0) begin
      errs++;
      $display("FAIL reset_outputs: got %h want 0", {pin, ovf, ocm, wrap, wval, stop, busy});
    end
    rst = 0;
    step();
    checks++;
    if (pin !== 1'b1) begin errs++; $display("FAIL reset_pin_pol: got %b want 1", pin); end
    pol = 0;
    step();
    checks++;
    if (pin !== 1'b0) begin errs++; $display("FAIL idle_pin: got %b want 0", pin); end
  endtask

  task automatic test_cc_periodic();
    int k, nocm;
    nocm = 0;
    disable_idle();
    cc = 1; per = 1; fpwm = 0; pol = 0; dir = 1; top = 16'h0009; ocr = 16'h0004;
    en = 1;
    step();
    checks++;
    if (busy !== 1'b1 || pin !== 1'b0) begin
      errs++; $display("FAIL cc_start: got busy=%b pin=%b want busy=1 pin=0", busy, pin);
    end
    for (int i = 0; i < 40; i++) begin
      cnt = 16'(i % 10); tick = 1;
      step();
      k = i / 10 + (((i % 10) >= 4) ? 1 : 0);
      if (ocm) nocm++;
      checks++;
      if (ocm !== (cnt == 16'd4)) begin errs++; $display("FAIL cc_ocm i=%0d: got %b want %b", i, ocm, cnt == 16'd4); end
      checks++;
      if (ovf !== (cnt == 16'd9) || wrap !== (cnt == 16'd9)) begin
        errs++; $display("FAIL cc_ovf i=%0d: got ovf=%b wrap=%b want %b", i, ovf, wrap, cnt == 16'd9);
      end
      checks++;
      if (pin !== k[0]) begin errs++; $display("FAIL cc_pin i=%0d: got %b want %b", i, pin, k[0]); end
      if (cnt == 16'd9) begin
        checks++;
        if (wval !== 16'h0000) begin errs++; $display("FAIL cc_wrap_val i=%0d: got %h want 0000", i, wval); end
      end
    end
    checks++;
    if (nocm != 4) begin errs++; $display("FAIL cc_ocm_count: got %0d want 4", nocm); end
  endtask

  // Fast PWM with CC also set (fpwm must take priority). Pin is high after
  // the wrap tick (cnt==TOP) and for ticks with cnt below OCR.
  task automatic test_fpwm();
    logic exp;
    for (int p = 0; p < 3; p++) begin
      disable_idle();
      fpwm = 1; cc = 1; per = 1; dir = 1; top = 16'h00FF;
      pol  = (p == 1);
      ocr  = (p == 2) ? 16'h00FF : 16'h0040;
      en = 1;
      step();
      checks++;
      if (pin !== ~pol) begin errs++; $display("FAIL pwm_start p=%0d: got %b want %b", p, pin, ~pol); end
      for (int i = 0; i < 300; i++) begin
        cnt = 16'(i % 256); tick = 1;
        step();
        exp = ((cnt == top) || (cnt < ocr)) ^ pol;
        checks++;
        if (pin !== exp) begin errs++; $display("FAIL pwm_pin p=%0d cnt=%h: got %b want %b", p, cnt, pin, exp); end
        checks++;
        if (ovf !== (cnt == 16'h00FF) || ocm !== (cnt == ocr)) begin
          errs++; $display("FAIL pwm_flags p=%0d cnt=%h: got ovf=%b ocm=%b", p, cnt, ovf, ocm);
        end
      end
    end
  endtask

  task automatic test_single_shot();
    int novf;
    for (int r = 0; r < 2; r++) begin
      disable_idle();
      checks++;
      if (stop !== 1'b0 || busy !== 1'b0) begin
        errs++; $display("FAIL ss_idle r=%0d: got stop=%b busy=%b want 0 0", r, stop, busy);
      end
      fpwm = 0; cc = 0; per = 0; pol = 0; dir = 1; top = 16'h0003; ocr = 16'h0001;
      en = 1;
      step();
      novf = 0;
      for (int i = 0; i < 9; i++) begin
        cnt = (i < 4) ? 16'(i) : 16'h0003; tick = 1;
        step();
        if (ovf) novf++;
        checks++;
        if (ovf !== (i == 3) || wrap !== (i == 3)) begin
          errs++; $display("FAIL ss_ovf r=%0d i=%0d: got ovf=%b wrap=%b want %b", r, i, ovf, wrap, i == 3);
        end
        checks++;
        if (stop !== (i >= 3) || busy !== (i < 3)) begin
          errs++; $display("FAIL ss_state r=%0d i=%0d: got stop=%b busy=%b want %b %b", r, i, stop, busy, i >= 3, i < 3);
        end
        checks++;
        if (pin !== 1'b0) begin errs++; $display("FAIL ss_pin r=%0d i=%0d: got %b want 0", r, i, pin); end
      end
      checks++;
      if (novf != 1) begin errs++; $display("FAIL ss_ovf_count r=%0d: got %0d want 1", r, novf); end
    end
  endtask

  task automatic test_down();
    disable_idle();
    fpwm = 0; cc = 1; per = 1; pol = 0; dir = 0; top = 16'h0005; ocr = 16'h0007;
    en = 1;
    step();
    for (int i = 0; i < 18; i++) begin
      cnt = 16'(5 - (i % 6)); tick = 1;
      step();
      checks++;
      if (wrap !== (cnt == 16'd0) || ovf !== (cnt == 16'd0)) begin
        errs++; $display("FAIL dn_wrap cnt=%h: got wrap=%b ovf=%b want %b", cnt, wrap, ovf, cnt == 16'd0);
      end
      checks++;
      if (ocm !== 1'b0 || pin !== 1'b0) begin
        errs++; $display("FAIL dn_no_match cnt=%h: got ocm=%b pin=%b want 0 0", cnt, ocm, pin);
      end
      if (cnt == 16'd0) begin
        checks++;
        if (wval !== 16'h0005) begin errs++; $display("FAIL dn_wrap_val: got %h want 0005", wval); end
      end
    end
    // No tick: holding cnt at 0 must not produce events.
    cnt = 0; tick = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (ovf !== 1'b0 || wrap !== 1'b0) begin
        errs++; $display("FAIL dn_notick i=%0d: got ovf=%b wrap=%b want 0 0", i, ovf, wrap);
      end
    end
  endtask

  task automatic test_en_drop();
    disable_idle();
    fpwm = 1; cc = 0; per = 1; pol = 1; dir = 1; top = 16'h0009; ocr = 16'h0004;
    en = 1;
    step();
    checks++;
    if (pin !== 1'b0) begin errs++; $display("FAIL drop_start: got %b want 0", pin); end
    for (int i = 0; i < 9; i++) begin
      cnt = 16'(i); tick = 1;
      step();
    end
    cnt = 16'h0009; tick = 1; en = 0;
    step();
    checks++;
    if (ovf !== 1'b0 || wrap !== 1'b0) begin
      errs++; $display("FAIL drop_suppress: got ovf=%b wrap=%b want 0 0", ovf, wrap);
    end
    checks++;
    if (busy !== 1'b0 || pin !== 1'b1) begin
      errs++; $display("FAIL drop_idle: got busy=%b pin=%b want 0 1", busy, pin);
    end
    tick = 0;
  endtask

  task automatic test_rst_done();
    disable_idle();
    fpwm = 1; cc = 0; per = 0; pol = 0; dir = 1; top = 16'h0003; ocr = 16'h0001;
    en = 1;
    step();
    for (int i = 0; i < 4; i++) begin
      cnt = 16'(i); tick = 1;
      step();
    end
    checks++;
    if (stop !== 1'b1 || pin !== 1'b1 || ovf !== 1'b1) begin
      errs++; $display("FAIL done_entry: got stop=%b pin=%b ovf=%b want 1 1 1", stop, pin, ovf);
    end
    tick = 0; rst = 1;
    step();
    checks++;
    if ({pin, ovf, ocm, wrap, wval, stop, busy} !== 22'd0) begin
      errs++; $display("FAIL done_reset: got %h want 0", {pin, ovf, ocm, wrap, wval, stop, busy});
    end
    rst = 0;
    step();
    checks++;
    if (busy !== 1'b1 || stop !== 1'b0) begin
      errs++; $display("FAIL done_restart: got busy=%b stop=%b want 1 0", busy, stop);
    end
  endtask

  initial begin
    test_reset();
    test_cc_periodic();
    test_fpwm();
    test_single_shot();
    test_down();
    test_en_drop();
    test_rst_done();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
